adc_sample_frontend: RTL and testbench

Serial ADC front-end for the SWIPT receiver. It drives a 12-bit SPI ADC (16-clock frame, 4 leading zeros then 12 data bits, MSB first) at a fixed sample rate. It optionally block-averages the samples and presents the 12-bit `adc_out` word consumed by the frequency-search stage, together with a per-result strobe. It sits between the board ADC pins and the frequency algorithm.

---
 rtl/adc_sample_frontend.sv | 195 +++++++++++++++++++
 tb/tb_adc_sample_frontend.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_frontend.sv
// adc_sample_frontend: SPI ADC frame sequencer (16-clock frame, 12-bit result).
// Define ADC_AVG_EN to report the truncated mean of every 2**AVG_LOG2 valid samples.
module adc_sample_frontend #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter int unsigned AVG_LOG2      = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        sdata,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] adc_out,
  output logic        adc_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned DivW   = $clog2(CLK_DIV);
  localparam int unsigned TimerW = $clog2(SAMPLE_PERIOD);
  localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StWait} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       sreg_q, sreg_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic [11:0]       out_q, out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              div_end;

`ifdef ADC_AVG_EN
  localparam int unsigned AccW = 12 + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign sum = acc_q + AccW'(sreg_q[11:0]);
`endif

  assign div_end = (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      sreg_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ADC_AVG_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      sreg_q  <= sreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef ADC_AVG_EN
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + DivW'(1);
    bit_d   = bit_q;
    timer_d = timer_q + TimerW'(1);
    sreg_d  = sreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef ADC_AVG_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        div_d   = '0;
        timer_d = '0;
        if (enable) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (div_end) begin
          state_d = StShift;
          sclk_d  = 1'b0;
          div_d   = '0;
        end
      end
      StShift: begin
        if (div_end) begin
          div_d = '0;
          if (!sclk_q) begin
            // ADC updates sdata after the falling edge; capture as sclk rises.
            sclk_d = 1'b1;
            sreg_d = {sreg_q[14:0], sdata};
          end else if (bit_q == 4'd15) begin
            state_d = StHold;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end
      end
      StHold: begin
        if (div_end) begin
          state_d = StWait;
          cs_n_d  = 1'b1;
          div_d   = '0;
          if (sreg_q[15:12] != 4'd0) begin
            err_d = 1'b1;
          end else begin
`ifdef ADC_AVG_EN
            if (cnt_q == CntLast) begin
              out_d   = sum[AVG_LOG2 +: 12];
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CntW'(1);
            end
`else
            out_d   = sreg_q[11:0];
            valid_d = 1'b1;
`endif
          end
        end
      end
      StWait: begin
        div_d = '0;
        if (timer_q == TimerLast) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          timer_d = '0;
          bit_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable abandons everything except the last reported result.
    if (state_q != StIdle && !enable) begin
      state_d = StIdle;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b1;
      out_d   = out_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
`ifdef ADC_AVG_EN
      acc_d   = '0;
      cnt_d   = '0;
`endif
    end
  end

  always_comb begin
    cs_n      = cs_n_q;
    sclk      = sclk_q;
    busy      = ~cs_n_q;
    adc_out   = out_q;
    adc_valid = valid_q;
    frame_err = err_q;
  end

endmodule

// File: tb/tb_adc_sample_frontend.sv
// Scoreboard bench for adc_sample_frontend: ADC word model, expected-result queue, monitor.
`timescale 1ns/1ps
module tb_adc_sample_frontend;

  localparam int ClkDiv       = 4;
  localparam int SamplePeriod = 200;
  localparam int FrameCycles  = 34 * ClkDiv;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable = 1'b0;
  logic        sdata = 1'b0;
  logic        cs_n, sclk, adc_valid, frame_err, busy;
  logic [11:0] adc_out;

  adc_sample_frontend #(
    .CLK_DIV      (ClkDiv),
    .SAMPLE_PERIOD(SamplePeriod),
    .AVG_LOG2     (3)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .sdata    (sdata),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .adc_out  (adc_out),
    .adc_valid(adc_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  typedef struct {
    bit          err;
    logic [11:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] adc_q[$];

  task automatic frame_word(input logic [15:0] w);
    adc_q.push_back(w);
  endtask

  task automatic expect_res(input bit err, input logic [11:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // ADC model: new word at cs_n fall, next bit after each sclk fall.
  logic [15:0] cur_word = '0;
  int          bit_idx = 0;
  int          frames_started = 0;
  int          m_fall_cyc = 0;
  logic        m_cs_prev = 1'b1;
  logic        m_sclk_prev = 1'b1;

  always @(negedge clk) begin
    if (m_cs_prev === 1'b1 && cs_n === 1'b0) begin
      frames_started++;
      m_fall_cyc = cyc;
      cur_word   = (adc_q.size() > 0) ? adc_q.pop_front() : 16'hFFFF;
      bit_idx    = 16;
      sdata      = 1'b0;
    end else if (cs_n === 1'b0 && m_sclk_prev === 1'b1 && sclk === 1'b0 && bit_idx > 0) begin
      bit_idx--;
      sdata = cur_word[bit_idx];
    end
    m_cs_prev   = cs_n;
    m_sclk_prev = sclk;
  end

  // Monitor: timing, protocol and scoreboard comparison on every strobe.
  int   gap_epoch = 0;
  int   fall_epoch = -1;
  int   fall_cyc = 0;
  int   sclk_falls = 0;
  logic mon_cs_prev = 1'b1;
  logic mon_sclk_prev = 1'b1;
  exp_t mon_e;

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      check_eq("busy_vs_cs_n", {31'b0, busy}, {31'b0, !cs_n});
      if (mon_cs_prev === 1'b1 && cs_n === 1'b0) begin
        if (fall_epoch == gap_epoch) check_eq("cs_fall_period", cyc - fall_cyc, SamplePeriod);
        fall_epoch = gap_epoch;
        fall_cyc   = cyc;
        sclk_falls = 0;
      end
      if (cs_n === 1'b0 && mon_sclk_prev === 1'b1 && sclk === 1'b0) sclk_falls++;
      if (adc_valid === 1'b1 || frame_err === 1'b1) begin
        check_eq("strobe_latency", cyc - fall_cyc, FrameCycles);
        check_eq("sclk_low_pulses", sclk_falls, 16);
        check_eq("cs_n_at_strobe", {31'b0, cs_n}, 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", {30'b0, frame_err, adc_valid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("strobe_kind", {30'b0, frame_err, adc_valid}, mon_e.err ? 2 : 1);
          check_eq("adc_out", {20'b0, adc_out}, {20'b0, mon_e.data});
        end
      end
    end
    mon_cs_prev   = cs_n;
    mon_sclk_prev = sclk;
  end

  task automatic wait_frames(input int n);
    int budget;
    budget = (n - frames_started + 1) * SamplePeriod + 100;
    while (frames_started < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("frame_start_timeout", frames_started >= n, 1);
  endtask

  task automatic drain();
    int budget;
    budget = 12 * SamplePeriod;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [11:0] want_out);
    check_eq({tag, "_cs_n"}, {31'b0, cs_n}, 1);
    check_eq({tag, "_sclk"}, {31'b0, sclk}, 1);
    check_eq({tag, "_adc_valid"}, {31'b0, adc_valid}, 0);
    check_eq({tag, "_frame_err"}, {31'b0, frame_err}, 0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 0);
    check_eq({tag, "_adc_out"}, {20'b0, adc_out}, {20'b0, want_out});
  endtask

  int          abort_idx;
  int          reset_idx;
  logic [11:0] hold_val;

  initial begin
    nrst   = 1'b0;
    enable = 1'b1;

`ifdef ADC_AVG_EN
    for (int i = 0; i < 8; i++) frame_word(16'h0100 + 16'(i));
    expect_res(1'b0, 12'h103);
    for (int i = 0; i < 8; i++) frame_word(16'h0FFF);
    expect_res(1'b0, 12'hFFF);
    frame_word(16'h0200); frame_word(16'h0202); frame_word(16'h0204);
    frame_word(16'hF123);
    expect_res(1'b1, 12'hFFF);
    frame_word(16'h0206); frame_word(16'h0208); frame_word(16'h020A);
    frame_word(16'h020C); frame_word(16'h020E);
    expect_res(1'b0, 12'h207);
    for (int i = 0; i < 3; i++) frame_word(16'h0300);
    frame_word(16'h0ABC);
    for (int i = 0; i < 8; i++) frame_word(16'h0010 + 16'(i));
    expect_res(1'b0, 12'h013);
    frame_word(16'h0888);
    for (int i = 0; i < 8; i++) frame_word(16'h0040);
    abort_idx = 29;
    reset_idx = 38;
    hold_val  = 12'h207;
`else
    frame_word(16'h0ABC); expect_res(1'b0, 12'hABC);
    frame_word(16'h0123); expect_res(1'b0, 12'h123);
    frame_word(16'h0FFF); expect_res(1'b0, 12'hFFF);
    frame_word(16'hF123); expect_res(1'b1, 12'hFFF);
    frame_word(16'h0005); expect_res(1'b0, 12'h005);
    frame_word(16'h0555);
    frame_word(16'h0777); expect_res(1'b0, 12'h777);
    frame_word(16'h0888);
    frame_word(16'h0999);
    abort_idx = 6;
    reset_idx = 8;
    hold_val  = 12'h005;
`endif

    repeat (5) @(negedge clk);
    check_idle_outputs("reset", 12'h000);
    gap_epoch++;
    nrst = 1'b1;
    @(negedge clk);
    check_eq("first_fall_after_reset", {31'b0, cs_n}, 0);

    // Abort in the 5th bit period (offsets 36..43 after cs_n fall).
    wait_frames(abort_idx);
    while (cyc - m_fall_cyc < 38) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort", hold_val);
    gap_epoch++;
    repeat (49) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check_eq("fall_after_reenable", {31'b0, cs_n}, 0);

    // One-cycle reset in the middle of SHIFT.
    wait_frames(reset_idx);
    while (cyc - m_fall_cyc < 40) @(negedge clk);
    gap_epoch++;
    nrst = 1'b0;
`ifdef ADC_AVG_EN
    expect_res(1'b0, 12'h040);
`else
    expect_res(1'b0, 12'h999);
`endif
    @(negedge clk);
    check_idle_outputs("midframe_reset", 12'h000);
    nrst = 1'b1;
    @(negedge clk);
    check_eq("fall_after_midframe_reset", {31'b0, cs_n}, 0);

    drain();
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("cs_n_after_disable", {31'b0, cs_n}, 1);
    check_eq("adc_words_left", adc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
